// File: rtl/lsu_bus_if.sv
// Memory request/response channel between the load/store unit and the data bus.
// The LSU drives the request half as master; the memory side answers as slave.
interface lsu_bus_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_bus.sv
// Handshaked load/store unit: one operation in flight, builds lane-aligned bus
// requests, extends load data and reports misalignment or bus errors to WBU.
module lsu_bus #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SB_W   = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in_exu,
  output logic              ready_out_exu,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        func3,
  input  logic [SB_W-1:0]   sb_in,
  output logic              valid_out_wbu,
  input  logic              ready_in_wbu,
  output logic [DATA_W-1:0] rdata_out,
  output logic              fault_out,
  output logic [SB_W-1:0]   sb_out,
  lsu_bus_if.master         mem
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

  state_t state, state_nx;

  // Doubles only fit a 64-bit bus; on a 32-bit bus they always fault.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] a,
                                         input logic [1:0]        sz);
    logic [2:0] low;
    low = a[2:0];
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return low[0];
      2'd2:    return |low[1:0];
      default: return (DATA_W != 64) || (|low);
    endcase
  endfunction

  function automatic logic [NB-1:0] store_strb(input logic [1:0]       sz,
                                               input logic [OFF_W-1:0] off);
    logic [NB-1:0] m;
    case (sz)
      2'd0:    m = NB'(8'h01);
      2'd1:    m = NB'(8'h03);
      2'd2:    m = NB'(8'h0F);
      default: m = NB'(8'hFF);
    endcase
    return m << off;
  endfunction

  // Move the addressed lane to bit 0, then left-justify it so a signed
  // arithmetic shift back down performs the sign extension.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] word,
                                                 input logic [OFF_W-1:0]  off,
                                                 input logic [2:0]        f3);
    logic [DATA_W-1:0]        s;
    logic signed [DATA_W-1:0] t;
    int                       sh;
    s = word >> {off, 3'b000};
    case (f3[1:0])
      2'd0:    sh = DATA_W - 8;
      2'd1:    sh = DATA_W - 16;
      2'd2:    sh = DATA_W - 32;
      default: sh = 0;
    endcase
    t = s << sh;
    if (f3[2]) return unsigned'(t) >> sh;
    else       return unsigned'(t >>> sh);
  endfunction

  logic memop, mis;
  assign memop = mem_ren | mem_wen;
  assign mis   = is_misaligned(addr, func3[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (valid_in_exu) state_nx = (memop && !mis) ? REQ : DONE;
      REQ:       if (mem.req_ready) state_nx = WAIT_RESP;
      WAIT_RESP: if (mem.resp_valid) state_nx = DONE;
      DONE:      if (ready_in_wbu) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  assign ready_out_exu = (state == IDLE);
  assign valid_out_wbu = (state == DONE);
  assign mem.req_valid = (state == REQ);

  logic [OFF_W-1:0]  off_p0;
  logic [2:0]        f3_p0;
  logic              load_p0;
  logic              req_wen_p0;
  logic [ADDR_W-1:0] req_addr_p0;
  logic [DATA_W-1:0] req_wdata_p0;
  logic [NB-1:0]     req_wstrb_p0;
  logic [SB_W-1:0]   sb_p0;
  logic [DATA_W-1:0] rdata_p1;
  logic              fault_p1;

  // Accept stage: capture the operation and pre-build the bus request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      off_p0       <= '0;
      f3_p0        <= '0;
      load_p0      <= 1'b0;
      req_wen_p0   <= 1'b0;
      req_addr_p0  <= '0;
      req_wdata_p0 <= '0;
      req_wstrb_p0 <= '0;
      sb_p0        <= '0;
      rdata_p1     <= '0;
      fault_p1     <= 1'b0;
    end else if (state == IDLE && valid_in_exu) begin
      off_p0       <= addr[OFF_W-1:0];
      f3_p0        <= func3;
      load_p0      <= mem_ren & ~mem_wen;
      req_wen_p0   <= mem_wen;
      req_addr_p0  <= {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
      req_wdata_p0 <= mem_wen ? (wdata << {addr[OFF_W-1:0], 3'b000}) : '0;
      req_wstrb_p0 <= mem_wen ? store_strb(func3[1:0], addr[OFF_W-1:0]) : '0;
      sb_p0        <= sb_in;
      rdata_p1     <= memop ? '0 : DATA_W'(addr);
      fault_p1     <= memop & mis;
    // Response stage: stores and errored loads report zero data
    end else if (state == WAIT_RESP && mem.resp_valid) begin
      fault_p1 <= mem.resp_err;
      rdata_p1 <= (load_p0 && !mem.resp_err) ? load_ext(mem.resp_rdata, off_p0, f3_p0) : '0;
    end
  end

  assign mem.req_wen   = req_wen_p0;
  assign mem.req_addr  = req_addr_p0;
  assign mem.req_wdata = req_wdata_p0;
  assign mem.req_wstrb = req_wstrb_p0;
  assign rdata_out     = rdata_p1;
  assign fault_out     = fault_p1;
  assign sb_out        = sb_p0;
endmodule

// File: tb/tb_lsu_bus.sv
// Scoreboarded bench for lsu_bus: a 32-bit and a 64-bit instance share one
// stimulus/response/monitor harness selected by sel.
module tb_lsu_bus;
  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          stall;
    int          delay;
    logic [63:0] mrd;
    logic        err;
  } req_t;

  typedef struct {
    logic [63:0]  rdata;
    logic         fault;
    logic [127:0] sb;
    int           lat;
    int           wstall;
  } res_t;

  logic         clk = 1'b0, rst_n = 1'b1, sel = 1'b0;
  logic         valid_in = 1'b0, ren = 1'b0, wen = 1'b0, ready_in_wbu = 1'b0;
  logic         req_ready = 1'b0, resp_valid = 1'b0, resp_err = 1'b0;
  logic [31:0]  addr = '0;
  logic [63:0]  wdata = '0, resp_rdata = '0;
  logic [2:0]   func3 = '0;
  logic [127:0] sb_in = '0;

  logic         rdy32, vld32, flt32, rdy64, vld64, flt64;
  logic [31:0]  rd32;
  logic [63:0]  rd64;
  logic [127:0] sb32, sb64;

  logic         ready_m, valid_m, fault_m, req_valid_m, req_wen_m;
  logic [63:0]  rdata_m, req_wdata_m;
  logic [127:0] sb_m;
  logic [31:0]  req_addr_m;
  logic [7:0]   req_wstrb_m;

  req_t req_q[$];
  res_t res_q[$];
  int   n_cmp = 0, n_fail = 0, n_done = 0, cyc = 0, acc_cyc = 0;

  lsu_bus_if #(.DATA_W(32), .ADDR_W(32)) bus32();
  lsu_bus_if #(.DATA_W(64), .ADDR_W(32)) bus64();

  assign bus32.req_ready  = req_ready & ~sel;
  assign bus32.resp_valid = resp_valid;
  assign bus32.resp_rdata = resp_rdata[31:0];
  assign bus32.resp_err   = resp_err;
  assign bus64.req_ready  = req_ready & sel;
  assign bus64.resp_valid = resp_valid;
  assign bus64.resp_rdata = resp_rdata;
  assign bus64.resp_err   = resp_err;

  lsu_bus #(.DATA_W(32), .ADDR_W(32), .SB_W(128)) u_dut32 (
    .clk(clk), .rst(rst_n), .valid_in_exu(valid_in & ~sel), .ready_out_exu(rdy32),
    .mem_ren(ren), .mem_wen(wen), .addr(addr), .wdata(wdata[31:0]), .func3(func3),
    .sb_in(sb_in), .valid_out_wbu(vld32), .ready_in_wbu(ready_in_wbu),
    .rdata_out(rd32), .fault_out(flt32), .sb_out(sb32), .mem(bus32));

  lsu_bus #(.DATA_W(64), .ADDR_W(32), .SB_W(128)) u_dut64 (
    .clk(clk), .rst(rst_n), .valid_in_exu(valid_in & sel), .ready_out_exu(rdy64),
    .mem_ren(ren), .mem_wen(wen), .addr(addr), .wdata(wdata), .func3(func3),
    .sb_in(sb_in), .valid_out_wbu(vld64), .ready_in_wbu(ready_in_wbu),
    .rdata_out(rd64), .fault_out(flt64), .sb_out(sb64), .mem(bus64));

  assign ready_m     = sel ? rdy64 : rdy32;
  assign valid_m     = sel ? vld64 : vld32;
  assign fault_m     = sel ? flt64 : flt32;
  assign rdata_m     = sel ? rd64 : {32'b0, rd32};
  assign sb_m        = sel ? sb64 : sb32;
  assign req_valid_m = sel ? bus64.req_valid : bus32.req_valid;
  assign req_wen_m   = sel ? bus64.req_wen : bus32.req_wen;
  assign req_addr_m  = sel ? bus64.req_addr : bus32.req_addr;
  assign req_wdata_m = sel ? bus64.req_wdata : {32'b0, bus32.req_wdata};
  assign req_wstrb_m = sel ? bus64.req_wstrb : {4'b0, bus32.req_wstrb};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from the architectural rules, on a 64-bit scratch word.
  function automatic void model(input int dw, input logic r, input logic w,
                                input logic [31:0] a, input logic [63:0] wd,
                                input logic [2:0] f3, input logic [63:0] mw, input logic e,
                                output logic has_req, output req_t rq, output res_t rs);
    int nb, bpw, off;
    logic [63:0] dmask, fm, v;
    nb = 1 << f3[1:0];
    bpw = dw / 8;
    off = int'(a % 32'(bpw));
    dmask = (dw == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
    has_req = 1'b0;
    rq.wen = 1'b0; rq.addr = '0; rq.wdata = '0; rq.wstrb = '0;
    rq.stall = 0; rq.delay = 0; rq.mrd = mw; rq.err = e;
    rs.rdata = '0; rs.fault = 1'b0; rs.sb = '0; rs.lat = 1; rs.wstall = 0;
    if (!r && !w) begin
      rs.rdata = {32'b0, a} & dmask;
    end else if ((a % 32'(nb)) != 0 || nb > bpw) begin
      rs.fault = 1'b1;
    end else begin
      has_req = 1'b1;
      rq.wen = w;
      rq.addr = a & ~32'(bpw - 1);
      rs.fault = e;
      rs.lat = 3;
      if (w) begin
        rq.wdata = ((wd & dmask) << (8 * off)) & dmask;
        rq.wstrb = 8'((1 << nb) - 1) << off;
      end else begin
        fm = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        v = ((mw & dmask) >> (8 * off)) & fm;
        if (!f3[2] && v[8*nb-1]) v = v | ~fm;
        rs.rdata = e ? 64'd0 : (v & dmask);
      end
    end
  endfunction

  task automatic run_op(input logic r, input logic w, input logic [31:0] a,
                        input logic [63:0] wd, input logic [2:0] f3, input logic [127:0] sb,
                        input logic [63:0] mw, input logic e, input int st, input int dl, input int ws);
    req_t rq; res_t rs; logic hr; int target, t;
    model(sel ? 64 : 32, r, w, a, wd, f3, mw, e, hr, rq, rs);
    rq.stall = st; rq.delay = dl;
    rs.sb = sb; rs.wstall = ws;
    if (hr) begin
      rs.lat = 3 + st + dl;
      req_q.push_back(rq);
    end
    res_q.push_back(rs);
    target = n_done + 1;
    @(negedge clk);
    chk("ready_out_exu_idle", ready_m, 1'b1);
    valid_in = 1'b1; ren = r; wen = w; addr = a; wdata = wd; func3 = f3; sb_in = sb;
    acc_cyc = cyc + 1;
    @(negedge clk);
    valid_in = 1'b0; ren = $urandom_range(0, 1); wen = $urandom_range(0, 1);
    addr = $urandom; wdata = {$urandom, $urandom}; func3 = 3'($urandom);
    sb_in = {$urandom, $urandom, $urandom, $urandom};
    t = 0;
    while (n_done < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (n_done < target) begin
      chk("completion_timeout", 0, 1);
      req_q.delete(); res_q.delete();
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      n_done = target;
    end
  endtask

  // Memory responder: checks each request and its stability across stalls.
  always begin : responder
    req_t r;
    logic [31:0] sa; logic [63:0] sd; logic [7:0] ss; logic sw;
    @(negedge clk);
    if (rst_n === 1'b1 && req_valid_m === 1'b1) begin
      sa = req_addr_m; sd = req_wdata_m; ss = req_wstrb_m; sw = req_wen_m;
      if (req_q.size() == 0) begin
        chk("unexpected_request", 1, 0);
        r.wen = 0; r.addr = 0; r.wdata = 0; r.wstrb = 0;
        r.stall = 0; r.delay = 0; r.mrd = 0; r.err = 0;
      end else begin
        r = req_q.pop_front();
        chk("req_addr", sa, r.addr);
        chk("req_wen", sw, r.wen);
        chk("req_wdata", sd, r.wdata);
        chk("req_wstrb", ss, r.wstrb);
      end
      repeat (r.stall) begin
        @(negedge clk);
        chk("req_valid_held", req_valid_m, 1'b1);
        chk("req_fields_stable", {sa, sd, ss, sw}, {req_addr_m, req_wdata_m, req_wstrb_m, req_wen_m});
      end
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      repeat (r.delay) @(negedge clk);
      resp_valid = 1'b1; resp_rdata = r.mrd; resp_err = r.err;
      @(negedge clk);
      resp_valid = 1'b0; resp_rdata = {$urandom, $urandom}; resp_err = 1'b1;
    end
  end

  // Result monitor: pops the scoreboard and applies WBU back-pressure.
  always begin : monitor
    res_t e;
    @(negedge clk);
    if (rst_n === 1'b1 && valid_m === 1'b1) begin
      if (res_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
        ready_in_wbu = 1'b1; @(negedge clk); ready_in_wbu = 1'b0;
      end else begin
        e = res_q.pop_front();
        chk("rdata_out", rdata_m, e.rdata);
        chk("fault_out", fault_m, e.fault);
        chk("sb_out", sb_m, e.sb);
        chk("latency", cyc - acc_cyc + 1, e.lat);
        chk("ready_out_exu_busy", ready_m, 1'b0);
        chk("request_consumed", req_q.size(), 0);
        repeat (e.wstall) begin
          @(negedge clk);
          chk("valid_held", valid_m, 1'b1);
          chk("outputs_held", {rdata_m, fault_m, sb_m}, {e.rdata, e.fault, e.sb});
        end
        ready_in_wbu = 1'b1;
        @(negedge clk);
        ready_in_wbu = 1'b0;
        n_done++;
      end
    end
  end

  task automatic random_ops(input int n);
    int kind, nb, st, dl, ws; logic r, w, e; logic [2:0] f3; logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 3);
      r = (kind == 1) || (kind == 3);
      w = (kind == 2) || (kind == 3);
      f3 = 3'($urandom);
      nb = 1 << f3[1:0];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
      e = ($urandom_range(0, 7) == 0);
      st = $urandom_range(0, 3); dl = $urandom_range(0, 3); ws = $urandom_range(0, 2);
      run_op(r, w, a, {$urandom, $urandom}, f3, {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom}, e, st, dl, ws);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #2;
    chk("rst_ready_out_exu", {rdy32, rdy64}, 2'b11);
    chk("rst_valid_out_wbu", {vld32, vld64}, 2'b00);
    chk("rst_req_valid_wen", {bus32.req_valid, bus64.req_valid, bus32.req_wen, bus64.req_wen}, 4'b0);
    chk("rst_data_outputs", {rd32, rd64, flt32, flt64}, '0);
    chk("rst_sb_out", sb32 | sb64, '0);
    chk("rst_req_fields", {bus32.req_addr, bus64.req_addr, bus32.req_wdata, bus64.req_wdata,
                           bus32.req_wstrb, bus64.req_wstrb}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    sel = 1'b0;
    run_op(0, 0, 32'h8000_0010, 64'h0, 3'b010, 128'hABCD, 64'h0, 0, 0, 0, 0);
    run_op(1, 0, 32'h0000_0013, 64'h0, 3'b000, 128'h1, 64'h80FF_1234, 0, 0, 0, 0);
    run_op(1, 0, 32'h0000_0013, 64'h0, 3'b100, 128'h2, 64'h80FF_1234, 0, 0, 0, 0);
    run_op(0, 1, 32'h0000_0022, 64'h0000_BEEF, 3'b001, 128'h3, 64'h0, 0, 0, 0, 0);
    run_op(1, 0, 32'h0000_0002, 64'h0, 3'b010, 128'h4, 64'h0, 0, 0, 0, 0);
    run_op(1, 0, 32'h0000_0004, 64'h0, 3'b010, 128'h5, 64'h1234_5678, 1, 0, 0, 0);
    run_op(1, 0, 32'h0000_0008, 64'h0, 3'b010, 128'h6, 64'hCAFE_F00D, 0, 3, 4, 2);
    run_op(1, 0, 32'h0000_0000, 64'h0, 3'b011, 128'h7, 64'h0, 0, 0, 0, 0);
    run_op(1, 1, 32'h0000_0031, 64'h0000_00A5, 3'b000, 128'h8, 64'h0, 0, 1, 1, 1);
    random_ops(150);

    sel = 1'b1;
    run_op(1, 0, 32'h0000_0008, 64'h0, 3'b011, 128'h9, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0);
    run_op(1, 0, 32'h0000_000C, 64'h0, 3'b110, 128'hA, 64'h8765_4321_0000_0000, 0, 0, 0, 0);
    run_op(1, 0, 32'h0000_000C, 64'h0, 3'b010, 128'hB, 64'h8765_4321_0000_0000, 0, 0, 0, 0);
    run_op(0, 1, 32'h0000_0004, 64'h1122_3344, 3'b010, 128'hC, 64'h0, 0, 2, 0, 0);
    run_op(1, 0, 32'h0000_0010, 64'h0, 3'b011, 128'hD, 64'h0, 0, 0, 0, 0);
    random_ops(150);

    begin : reset_abort
      req_t rq; res_t rs; logic hr;
      model(64, 1, 0, 32'h10, 64'h0, 3'b011, 64'h5555_AAAA_5555_AAAA, 0, hr, rq, rs);
      rq.stall = 0; rq.delay = 6;
      req_q.push_back(rq);
      @(negedge clk);
      valid_in = 1'b1; ren = 1'b1; wen = 1'b0; addr = 32'h10; func3 = 3'b011; sb_in = 128'hFEED;
      @(negedge clk);
      valid_in = 1'b0; ren = 1'b0;
      @(negedge clk);
      chk("in_wait_resp_not_ready", ready_m, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("abort_ready_out_exu", ready_m, 1'b1);
      chk("abort_valid_out_wbu", valid_m, 1'b0);
      chk("abort_req_valid_wen", {req_valid_m, req_wen_m}, 2'b00);
      chk("abort_data_outputs", {rdata_m, fault_m, sb_m}, '0);
      chk("abort_req_fields", {req_addr_m, req_wdata_m, req_wstrb_m}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("late_resp_ignored_valid", valid_m, 1'b0);
      chk("late_resp_ignored_ready", ready_m, 1'b1);
    end

    run_op(1, 0, 32'h0000_0018, 64'h0, 3'b011, 128'hE, 64'h0102_0304_0506_0708, 0, 1, 2, 1);
    chk("scoreboard_drained", res_q.size() + req_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_bus.md
# lsu_bus

Parametrised load/store unit between EXU and WBU. It replaces the fixed one-cycle LSU stage with a handshaked memory request/response port that tolerates any latency. It supports a 32- or 64-bit datapath, builds byte strobes and extends load data internally, flags misaligned accesses and bus errors, and carries an opaque sideband bundle (pc, rd, CSR fields, etc.) to WBU.

## Interface
- DATA_W, 32, datapath width; legal values 32 or 64.
- ADDR_W, 32, address width.
- SB_W, 128, width of the sideband bundle passed through to WBU unchanged.
---
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. Asserting it forces state to IDLE and clears all registers immediately.
- valid_in_exu  in  1  EXU presents an operation.
- ready_out_exu  out  1  LSU can accept an operation.
- mem_ren, mem_wen  in  1 each  operation is a load / a store. Both 0 means pass-through. Both 1 is illegal and is treated as a store.
- addr  in  ADDR_W  byte address (ALU result).
- wdata  in  DATA_W  store data, LSB-aligned.
- func3  in  3  RISC-V size/sign encoding.
- sb_in  in  SB_W  sideband bundle.
- valid_out_wbu  out  1  result is valid.
- ready_in_wbu  in  1  WBU accepts the result.
- rdata_out  out  DATA_W  extended load data, or addr zero-extended for pass-through.
- fault_out  out  1  misaligned access or bus error.
- sb_out  out  SB_W  registered copy of sb_in.
- req_valid  out  1  memory request is valid.
- req_ready  in  1  memory accepts the request.
- req_wen  out  1  request is a write.
- req_addr  out  ADDR_W  addr with its low log2(DATA_W/8) bits cleared.
- req_wdata  out  DATA_W  store data shifted to its byte lane.
- req_wstrb  out  DATA_W/8  byte strobes.
- resp_valid  in  1  response is valid (load data or write acknowledge).
- resp_rdata  in  DATA_W  full bus word.
- resp_err  in  1  bus error; sampled together with resp_valid.

## Operation
- States: IDLE, REQ, WAIT_RESP, DONE.
  - IDLE: ready_out_exu=1. When valid_in_exu=1 the operation is accepted: addr, wdata, func3, mem_ren, mem_wen and sb_in are captured.
    - Pass-through goes to DONE.
    - A misaligned memory op goes to DONE with fault=1 and no bus request is issued.
    - Any other memory op goes to REQ.
  - REQ: req_valid=1, with all req_* fields held stable from registers. When req_ready=1 the state moves to WAIT_RESP.
  - WAIT_RESP: when resp_valid=1, rdata_out and fault_out are captured and the state moves to DONE. fault_out takes resp_err. resp_valid is ignored in every other state.
  - DONE: valid_out_wbu=1 and all outputs are held. When ready_in_wbu=1 the state returns to IDLE.
- Sizes, from func3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = double.
  - Double is legal only when DATA_W=64. When DATA_W=32, double is treated as misaligned (fault).
- Misaligned: the address is not a multiple of the access size.
- Byte offset: off = addr[log2(DATA_W/8)-1:0].
- Store strobes: req_wstrb = ((1<<size_bytes)-1) << off.
- Store data: req_wdata = wdata << (8*off).
- Loads: the response word is shifted right by 8*off, then truncated to the access size.
  - func3[2]=0: sign-extend.
  - func3[2]=1: zero-extend. This covers LBU, LHU and, when DATA_W=64, LWU.
- Load with fault: rdata_out=0.
- Store: rdata_out=0, and the operation completes on its write acknowledge (resp_valid).

## Timing
- Reset values: state=IDLE, ready_out_exu=1, valid_out_wbu=0, req_valid=0, req_wen=0, and every data output (including sb_out) is 0.
- ready_out_exu and valid_out_wbu are decoded from the state register only. There is no combinational path from any input to any output.
- Latency, counted from the accept edge to the first valid_out_wbu cycle:
  - Pass-through or misaligned: 1 cycle.
  - Memory op with req_ready=1 and resp_valid one cycle after the request handshake: 3 cycles.
  - Each stall cycle on req_ready or resp_valid adds 1 cycle.
- Only one operation is in flight. A new operation is accepted on the first IDLE cycle after the DONE handshake, so peak throughput is one operation per 2 cycles.
- Back-pressure: while ready_in_wbu=0, DONE holds rdata_out, fault_out and sb_out unchanged.
- Reset mid-operation (REQ or WAIT_RESP) aborts the operation. A late resp_valid arriving after reset is ignored, because the block is then in IDLE.

## Test plan
- Pass-through, addr=0x8000_0010, sb_in=0xABCD, ready_in_wbu=1 -> valid_out_wbu one cycle after accept, rdata_out=0x8000_0010, sb_out=0xABCD, req_valid never asserted.
- DATA_W=32, LB at addr=0x13, resp_rdata=0x80FF_1234 -> req_addr=0x10; rdata_out=0xFFFF_FF80, fault_out=0. Repeat as LBU -> rdata_out=0x0000_0080.
- SH at addr=0x22, wdata=0x0000_BEEF -> req_wstrb=4'b1100, req_wdata=0xBEEF_0000, req_wen=1; completes on write acknowledge with rdata_out=0.
- LW at addr=0x02 -> no bus request; valid_out_wbu one cycle after accept with fault_out=1 and rdata_out=0. Separately, LW at 0x04 with resp_err=1 -> fault_out=1.
- Stalls: req_ready low for 3 cycles, resp_valid delayed 4 cycles, ready_in_wbu low for 2 cycles -> req_* fields stable throughout, latency 3+3+4=10 cycles, outputs held until the WBU handshake.
- DATA_W=64, LD at addr=0x08 -> full 64-bit word returned; reset asserted while in WAIT_RESP -> outputs return to their reset values at once, a later resp_valid is ignored, and ready_out_exu=1.
